// File: rtl/melody_pkg.sv
// Shared definitions for the melody player: FSM states, song-entry layout
// and the note-code to tone half-period table.
package melody_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  localparam int NOTE_W = 4;
  localparam int HP_W   = 16;
  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;

  // Half-periods assume an 8 MHz clock; code 15 is a fast calibration tone.
  function automatic logic [HP_W-1:0] note_hp(input logic [NOTE_W-1:0] code);
    logic [HP_W-1:0] hp;
    case (code)
      4'd0:    hp = 16'd0;
      4'd1:    hp = 16'd15288;
      4'd2:    hp = 16'd13620;
      4'd3:    hp = 16'd12134;
      4'd4:    hp = 16'd11453;
      4'd5:    hp = 16'd10203;
      4'd6:    hp = 16'd9090;
      4'd7:    hp = 16'd8098;
      4'd8:    hp = 16'd7644;
      4'd9:    hp = 16'd6810;
      4'd10:   hp = 16'd6067;
      4'd11:   hp = 16'd5726;
      4'd12:   hp = 16'd5101;
      4'd13:   hp = 16'd4544;
      4'd14:   hp = 16'd4049;
      4'd15:   hp = 16'd9;
      default: hp = 16'd0;
    endcase
    return hp;
  endfunction

endpackage

// File: rtl/melody_player_tone_gen.sv
// Square-wave generator: toggles the speaker every HP+1 cycles, restarting
// phase-aligned (speaker low, counter at HP) whenever a note is loaded.
module tone_gen #(
  parameter int DIV_W = 14
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [DIV_W-1:0] i_hp,
  input  logic             i_load,
  input  logic             i_enable,
  output logic             o_speaker
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_spk;

  // Half-period down-counter and speaker flip-flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_spk <= 1'b0;
    end else if (!i_enable) begin
      r_cnt <= '0;
      r_spk <= 1'b0;
    end else if (i_load) begin
      r_cnt <= i_hp;
      r_spk <= 1'b0;
    end else if (r_cnt == '0) begin
      r_cnt <= i_hp;
      r_spk <= ~r_spk;
    end else begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

  assign o_speaker = r_spk;

endmodule

// File: rtl/melody_player.sv
// Song sequencer: steps through a small song RAM of {note, duration} entries
// on tempo ticks and drives a tone generator for the current note.
module melody_player
  import melody_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DIV_W  = 14,
  parameter int DUR_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [NOTE_W+DUR_W-1:0] wr_data,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    loop_en,
  input  logic [ADDR_W-1:0]       last_addr,
  output logic                    speaker,
  output logic [NOTE_W-1:0]       note,
  output logic [ADDR_W-1:0]       addr,
  output logic                    busy,
  output logic                    done
);

  localparam int ENTRY_W = NOTE_W + DUR_W;
  localparam int DEPTH   = 1 << ADDR_W;

  logic [ENTRY_W-1:0] r_mem [0:DEPTH-1];

  state_t             r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_last;
  logic [NOTE_W-1:0]  r_note;
  logic [DUR_W:0]     r_beats;
  logic               r_loop;
  logic               r_busy;
  logic               r_done;

  logic               w_adv;
  logic               w_end;
  logic               w_load;
  logic               w_tone_en;
  logic [ADDR_W-1:0]  w_next_addr;
  logic [ENTRY_W-1:0] w_entry;
  logic [NOTE_W-1:0]  w_entry_note;
  logic [DUR_W:0]     w_entry_beats;
  logic [NOTE_W-1:0]  w_tone_note;
  logic [DIV_W-1:0]   w_hp;

  // Song RAM: no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Next-entry fetch and tone-generator control, decided in the load cycle.
  always_comb begin
    w_adv = (r_state == ST_PLAY) && tick && (r_beats == (DUR_W+1)'(1));
    w_end = w_adv && (r_addr == r_last) && !r_loop;

    if (r_state == ST_IDLE) begin
      w_next_addr = '0;
    end else if (r_addr == r_last) begin
      w_next_addr = '0;
    end else begin
      w_next_addr = r_addr + ADDR_W'(1);
    end

    w_entry       = r_mem[w_next_addr];
    w_entry_note  = w_entry[ENTRY_W-1:DUR_W];
    w_entry_beats = {1'b0, w_entry[DUR_W-1:0]} + (DUR_W+1)'(1);

    w_load = !stop && (((r_state == ST_IDLE) && start) || (w_adv && !w_end));

    if (w_load) begin
      w_tone_note = w_entry_note;
    end else begin
      w_tone_note = r_note;
    end

    w_tone_en = !stop && !w_end && (w_load || (r_state == ST_PLAY)) &&
                (w_tone_note != NOTE_REST);
    w_hp      = DIV_W'(note_hp(w_tone_note));
  end

  // Playback FSM with registered display/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_last  <= '0;
      r_note  <= '0;
      r_beats <= '0;
      r_loop  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop) begin
        r_state <= ST_IDLE;
        r_addr  <= '0;
        r_note  <= '0;
        r_beats <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state <= ST_PLAY;
              r_addr  <= '0;
              r_note  <= w_entry_note;
              r_beats <= w_entry_beats;
              r_last  <= last_addr;
              r_loop  <= loop_en;
              r_busy  <= 1'b1;
            end
          end
          ST_PLAY: begin
            if (tick) begin
              if (w_end) begin
                r_state <= ST_IDLE;
                r_addr  <= '0;
                r_note  <= '0;
                r_beats <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else if (w_adv) begin
                r_addr  <= w_next_addr;
                r_note  <= w_entry_note;
                r_beats <= w_entry_beats;
              end else begin
                r_beats <= r_beats - (DUR_W+1)'(1);
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_note  <= '0;
            r_beats <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  tone_gen #(
    .DIV_W(DIV_W)
  ) u_tone_gen (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_hp      (w_hp),
    .i_load    (w_load),
    .i_enable  (w_tone_en),
    .o_speaker (speaker)
  );

  assign note = r_note;
  assign addr = r_addr;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: doc/melody_player.md
MELODY_PLAYER -- requirements
Module: melody_player

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning song RAM address width (depth 2^ADDR_W entries).
REQ-002 SHALL have parameter DIV_W, default 14, meaning tone half-period counter width.
REQ-003 SHALL have parameter DUR_W, default 3, meaning per-note duration field width in beats minus one.
REQ-004 SHALL have port clk  input  1  single system clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port tick  input  1  tempo beat strobe, one clk wide.
REQ-007 SHALL have port wr_en  input  1  song RAM write strobe.
REQ-008 SHALL have port wr_addr  input  ADDR_W  song RAM write address.
REQ-009 SHALL have port wr_data  input  4+DUR_W  entry {note[3:0], dur[DUR_W-1:0]}.
REQ-010 SHALL have port start  input  1  begin playback at address 0.
REQ-011 SHALL have port stop  input  1  abort playback.
REQ-012 SHALL have port loop_en  input  1  1 = wrap to address 0 after last entry.
REQ-013 SHALL have port last_addr  input  ADDR_W  index of final song entry.
REQ-014 SHALL have port speaker  output  1  square-wave tone output.
REQ-015 SHALL have port note  output  4  note code currently sounding (display).
REQ-016 SHALL have port addr  output  ADDR_W  current song position.
REQ-017 SHALL have port busy  output  1  high in PLAY.
REQ-018 SHALL have port done  output  1  one-clk pulse at end of non-looped song.

Function
REQ-019 SHALL implement states IDLE and PLAY only.
REQ-020 SHALL, in IDLE on start=1 and stop=0, enter PLAY next cycle with addr=0, note=mem[0].note, beats-remaining=mem[0].dur+1, and latch last_addr and loop_en.
REQ-021 SHALL ignore start while in PLAY.
REQ-022 SHALL, in PLAY, decrement beats-remaining on each tick; on tick with beats-remaining=1 advance to next entry the following cycle.
REQ-023 SHALL, at advance from latched last_addr, wrap to addr 0 if latched loop_en=1, else go IDLE, clear note to 0, and assert done for exactly one cycle.
REQ-024 SHALL, on stop=1 in any state, go IDLE next cycle with speaker=0, note=0, addr=0, no done pulse; stop wins over simultaneous start or tick.
REQ-025 SHALL read song RAM combinationally; RAM writes in any state take effect for entries not yet loaded.
REQ-026 SHALL map note code via constant table to half-period HP (DIV_W bits); code 0 is rest.
REQ-027 SHALL, for non-rest notes, toggle speaker every HP+1 clk cycles (frequency clk/(2*(HP+1))).
REQ-028 SHALL, at every note load, reset tone counter to HP and force speaker=0 (phase-aligned start).
REQ-029 SHALL hold speaker=0 during rest and in IDLE.
REQ-030 SHALL treat all counters as unsigned, wrapping never required (HP loads, counts down to 0).

Reset
REQ-031 SHALL on rst_n=0 asynchronously force IDLE, speaker=0, note=0, addr=0, busy=0, done=0, counters=0.
REQ-032 SHALL NOT reset song RAM contents.
REQ-033 SHALL resume only via a new start after reset release, including reset mid-song.

Structure
REQ-034 SHALL place state enum, entry width constants and note-to-HP table function in package melody_pkg.
REQ-035 SHALL instantiate one sub-module tone_gen (HP in, load, enable -> speaker).

Verification
REQ-036 SHALL cover: mem[0]={3,1}, last_addr=0, loop_en=0, start, 4 ticks -> 2 beats of note 3, then done pulse once, busy=0.
REQ-037 SHALL cover: HP=9 note held 100 clks -> speaker period 20 clks, first rise 10 clks after load.
REQ-038 SHALL cover: last_addr=2, loop_en=1, 1-beat entries, 7 ticks -> addr sequence 0,1,2,0,1,2,0, no done.
REQ-039 SHALL cover: stop and tick same cycle mid-note -> IDLE next cycle, speaker=0, no done.
REQ-040 SHALL cover: note 0 entry -> speaker stays 0 for its full duration; busy=1.
REQ-041 SHALL cover: rst_n low mid-song -> outputs zero immediately without clk; start afterwards replays from addr 0 with RAM intact.
